// File: rtl/mppt_pkg.sv
// Shared types and helpers for the multi-channel perturb-and-observe MPPT engine.
package mppt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        CMP  = 2'd2
    } state_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Channel index width, never below one bit so a single-channel build still has a port.
    function automatic int calcChW(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/mppt_pwm.sv
// Shared free-running PWM counter with per-channel shadow duty registers.
module mppt_pwm #(
    parameter int NCH       = 2,
    parameter int DUTY_W    = 8,
    parameter int DUTY_INIT = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NCH*DUTY_W-1:0] duty_i,
    output logic [NCH-1:0]        pwm_o
);

    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic [DUTY_W-1:0] shadow_q [NCH];
    logic [DUTY_W-1:0] shadow_d [NCH];
    logic [NCH-1:0]    pwm_q, pwm_d;

    // Compare against next-cycle counter/shadow so the registered output tracks cnt < shadow without lag.
    always_comb begin
        cnt_d = cnt_q + DUTY_W'(1);
        pwm_d = '0;
        for (int c = 0; c < NCH; c++) begin
            shadow_d[c] = (cnt_q == '1) ? duty_i[c*DUTY_W +: DUTY_W] : shadow_q[c];
            pwm_d[c]    = (cnt_d < shadow_d[c]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            pwm_q <= '0;
            for (int c = 0; c < NCH; c++) shadow_q[c] <= DUTY_W'(DUTY_INIT);
        end else begin
            cnt_q    <= cnt_d;
            pwm_q    <= pwm_d;
            shadow_q <= shadow_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/mppt_po_multi.sv
// Multi-channel perturb-and-observe MPPT: time-multiplexed samples in, per-channel duty and PWM out.
module mppt_po_multi
    import mppt_pkg::*;
#(
    parameter  int NCH       = 2,
    parameter  int ADC_W     = 12,
    parameter  int DUTY_W    = 8,
    parameter  int DUTY_MIN  = 13,
    parameter  int DUTY_MAX  = 242,
    parameter  int DUTY_INIT = 128,
    localparam int CH_W      = calcChW(NCH)
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  en_i,
    input  logic [DUTY_W-1:0]     step_i,
    input  logic                  smp_valid_i,
    output logic                  smp_ready_o,
    input  logic [CH_W-1:0]       smp_ch_i,
    input  logic [ADC_W-1:0]      smp_v_i,
    input  logic [ADC_W-1:0]      smp_i_i,
    output logic [NCH*DUTY_W-1:0] duty_o,
    output logic [NCH-1:0]        dir_o,
    output logic [NCH-1:0]        pwm_o,
    output logic                  upd_o,
    output logic [CH_W-1:0]       upd_ch_o
);

    localparam int PW = 2 * ADC_W;

    state_e              state_q, state_d;
    logic                accept;
    logic [CH_W-1:0]     ch_q;
    logic [ADC_W-1:0]    v_q, i_q;
    logic [PW-1:0]       p_q;
    logic [DUTY_W-1:0]   duty_q  [NCH];
    logic [DUTY_W-1:0]   duty_d  [NCH];
    logic [PW-1:0]       pprev_q [NCH];
    logic [PW-1:0]       pprev_d [NCH];
    logic [NCH-1:0]      dir_q, dir_d, seen_q, seen_d;
    logic                upd_q, upd_d;
    logic [CH_W-1:0]     updCh_q, updCh_d;
    logic                newDir;
    logic [NCH*DUTY_W-1:0] dutyFlat;

    // Step is applied in DUTY_W+1 bits so both overflow and borrow land in the clamp.
    function automatic logic [DUTY_W-1:0] stepDuty(input logic [DUTY_W-1:0] duty,
                                                   input logic [DUTY_W-1:0] step,
                                                   input logic              up);
        logic [DUTY_W:0] sum;
        sum = up ? ({1'b0, duty} + {1'b0, step}) : ({1'b0, duty} - {1'b0, step});
        if (!up && sum[DUTY_W]) return DUTY_W'(DUTY_MIN);
        if (sum > (DUTY_W+1)'(DUTY_MAX)) return DUTY_W'(DUTY_MAX);
        if (sum < (DUTY_W+1)'(DUTY_MIN)) return DUTY_W'(DUTY_MIN);
        return sum[DUTY_W-1:0];
    endfunction

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = MUL;
            MUL:     state_d = CMP;
            CMP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        smp_ready_o = (state_q == IDLE);
    end

    assign accept = smp_valid_i & smp_ready_o;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ch_q <= '0;
            v_q  <= '0;
            i_q  <= '0;
            p_q  <= '0;
        end else begin
            if (accept) begin
                ch_q <= smp_ch_i;
                v_q  <= smp_v_i;
                i_q  <= smp_i_i;
            end
            if (state_q == MUL) p_q <= PW'(v_q) * PW'(i_q);
        end
    end

    // Out-of-range channel indices match no loop iteration, so such samples are silently dropped.
    always_comb begin
        duty_d  = duty_q;
        pprev_d = pprev_q;
        dir_d   = dir_q;
        seen_d  = seen_q;
        upd_d   = 1'b0;
        updCh_d = updCh_q;
        newDir  = DIR_UP;
        if (state_q == CMP) begin
            for (int c = 0; c < NCH; c++) begin
                if (ch_q == CH_W'(c)) begin
                    pprev_d[c] = p_q;
                    if (!seen_q[c]) begin
                        seen_d[c] = 1'b1;
                    end else if (en_i) begin
                        upd_d   = 1'b1;
                        updCh_d = ch_q;
                        if (p_q != pprev_q[c]) begin
                            newDir     = (p_q > pprev_q[c]) ? dir_q[c] : ~dir_q[c];
                            dir_d[c]   = newDir;
                            duty_d[c]  = stepDuty(duty_q[c], step_i, newDir);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int c = 0; c < NCH; c++) begin
                duty_q[c]  <= DUTY_W'(DUTY_INIT);
                pprev_q[c] <= '0;
            end
            dir_q   <= '1;
            seen_q  <= '0;
            upd_q   <= 1'b0;
            updCh_q <= '0;
        end else begin
            duty_q  <= duty_d;
            pprev_q <= pprev_d;
            dir_q   <= dir_d;
            seen_q  <= seen_d;
            upd_q   <= upd_d;
            updCh_q <= updCh_d;
        end
    end

    always_comb begin
        dutyFlat = '0;
        for (int c = 0; c < NCH; c++) dutyFlat[c*DUTY_W +: DUTY_W] = duty_q[c];
    end

    assign duty_o   = dutyFlat;
    assign dir_o    = dir_q;
    assign upd_o    = upd_q;
    assign upd_ch_o = updCh_q;

    mppt_pwm #(
        .NCH       (NCH),
        .DUTY_W    (DUTY_W),
        .DUTY_INIT (DUTY_INIT)
    ) uPwm (
        .clk_i  (wb_clk_i),
        .rst_i  (wb_rst_i),
        .duty_i (dutyFlat),
        .pwm_o  (pwm_o)
    );

endmodule

// File: tb/tb_mppt_po_multi.sv
// Scoreboard bench for mppt_po_multi; three channels so an out-of-range index (3) is representable.
module tb_mppt_po_multi;

    localparam int NCH   = 3;
    localparam int ADC_W = 12;
    localparam int DW    = 8;
    localparam int CH_W  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en_i;
    logic [DW-1:0]        step_i;
    logic                 smp_valid_i;
    logic                 smp_ready_o;
    logic [CH_W-1:0]      smp_ch_i;
    logic [ADC_W-1:0]     smp_v_i;
    logic [ADC_W-1:0]     smp_i_i;
    logic [NCH*DW-1:0]    duty_o;
    logic [NCH-1:0]       dir_o;
    logic [NCH-1:0]       pwm_o;
    logic                 upd_o;
    logic [CH_W-1:0]      upd_ch_o;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        logic [DW-1:0]   duty;
        logic            dir;
    } exp_t;

    exp_t    expQ[$];
    int      testsRun    = 0;
    int      testsFailed = 0;
    int      pushCount   = 0;
    int      updCount    = 0;
    logic [DW-1:0] cycCnt;

    mppt_po_multi #(
        .NCH       (NCH),
        .ADC_W     (ADC_W),
        .DUTY_W    (DW),
        .DUTY_MIN  (13),
        .DUTY_MAX  (242),
        .DUTY_INIT (128)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .en_i        (en_i),
        .step_i      (step_i),
        .smp_valid_i (smp_valid_i),
        .smp_ready_o (smp_ready_o),
        .smp_ch_i    (smp_ch_i),
        .smp_v_i     (smp_v_i),
        .smp_i_i     (smp_i_i),
        .duty_o      (duty_o),
        .dir_o       (dir_o),
        .pwm_o       (pwm_o),
        .upd_o       (upd_o),
        .upd_ch_o    (upd_ch_o)
    );

    always #5 clk = ~clk;

    // Reference PWM phase: counts edges since reset release, wrapping every 256 cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) cycCnt <= '0;
        else     cycCnt <= cycCnt + 8'd1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every upd_o pulse is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && upd_o === 1'b1) begin
            updCount++;
            if (expQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected upd: got upd on ch %0d expected no update", upd_ch_o);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("upd_ch", 32'(upd_ch_o), 32'(e.ch));
                checkOutput($sformatf("upd duty ch%0d", e.ch), 32'(duty_o[e.ch*DW +: DW]), 32'(e.duty));
                checkOutput($sformatf("upd dir ch%0d", e.ch), 32'(dir_o[e.ch]), 32'(e.dir));
            end
        end
    end

    task automatic applyStimulus(input logic [CH_W-1:0] ch, input int v, input int i, input int step,
                                 input logic en, input logic expUpd, input int expDuty, input logic expDir);
        int n;
        @(negedge clk);
        smp_ch_i    = ch;
        smp_v_i     = v[ADC_W-1:0];
        smp_i_i     = i[ADC_W-1:0];
        step_i      = step[DW-1:0];
        en_i        = en;
        smp_valid_i = 1'b1;
        n = 0;
        while (smp_ready_o !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (n >= 10) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL accept timeout: got ready=%0b expected 1", smp_ready_o);
            smp_valid_i = 1'b0;
            return;
        end
        if (expUpd) begin
            expQ.push_back(exp_t'{ch, expDuty[DW-1:0], expDir});
            pushCount++;
        end
        @(posedge clk);
        #1 smp_valid_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic checkPwmPeriod(input string name, input logic [NCH*DW-1:0] expDuty);
        int n;
        int bad [NCH];
        logic [DW-1:0] d;
        for (int c = 0; c < NCH; c++) bad[c] = 0;
        n = 0;
        @(negedge clk);
        while (cycCnt != 8'd0 && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s period start: got no wrap expected wrap within 600 cycles", name);
            return;
        end
        for (int k = 0; k < 256; k++) begin
            for (int c = 0; c < NCH; c++) begin
                d = expDuty[c*DW +: DW];
                if (pwm_o[c] !== (cycCnt < d)) bad[c]++;
            end
            if (k < 255) @(negedge clk);
        end
        for (int c = 0; c < NCH; c++)
            checkOutput($sformatf("%s pwm ch%0d bad cycles", name, c), 32'(bad[c]), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int last;
        int n;
        rst = 1'b1;
        en_i = 1'b1;
        step_i = '0;
        smp_valid_i = 1'b0;
        smp_ch_i = '0;
        smp_v_i = '0;
        smp_i_i = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset pwm", 32'(pwm_o), 32'd0);
        checkOutput("reset upd", 32'(upd_o), 32'd0);
        rst = 1'b0;
        checkOutput("reset duty", 32'(duty_o), 32'h808080);
        checkOutput("reset dir", 32'(dir_o), 32'b111);
        checkOutput("reset ready", 32'(smp_ready_o), 32'd1);
        checkOutput("reset upd_ch", 32'(upd_ch_o), 32'd0);
        checkPwmPeriod("idle", {8'd128, 8'd128, 8'd128});

        applyStimulus(2'd0, 100, 100, 4,   1'b1, 1'b0, 0,   1'b1);
        applyStimulus(2'd0, 110, 100, 4,   1'b1, 1'b1, 132, 1'b1);
        checkOutput("ch1 untouched", 32'(duty_o[15:8]), 32'd128);
        applyStimulus(2'd0, 105, 100, 4,   1'b1, 1'b1, 128, 1'b0);
        applyStimulus(2'd0, 105, 100, 4,   1'b1, 1'b1, 128, 1'b0);
        applyStimulus(2'd0, 100, 100, 112, 1'b1, 1'b1, 240, 1'b1);
        applyStimulus(2'd0, 120, 100, 10,  1'b1, 1'b1, 242, 1'b1);
        applyStimulus(2'd0, 110, 100, 227, 1'b1, 1'b1, 15,  1'b0);
        applyStimulus(2'd0, 120, 100, 10,  1'b1, 1'b1, 13,  1'b0);
        applyStimulus(2'd0, 90,  100, 10,  1'b0, 1'b0, 0,   1'b0);
        checkOutput("en0 duty held", 32'(duty_o[7:0]), 32'd13);
        applyStimulus(2'd0, 95,  100, 0,   1'b1, 1'b1, 13,  1'b0);
        applyStimulus(2'd3, 50,  100, 10,  1'b1, 1'b0, 0,   1'b0);
        checkOutput("bad ch duty", 32'(duty_o), 32'h80800D);
        checkOutput("bad ch dir", 32'(dir_o), 32'b110);

        // Valid held high: accepts must fall exactly three cycles apart.
        @(negedge clk);
        smp_ch_i = 2'd2;
        smp_v_i = 12'd50;
        smp_i_i = 12'd50;
        step_i = 8'd4;
        en_i = 1'b1;
        smp_valid_i = 1'b1;
        expQ.push_back(exp_t'{2'd2, 8'd128, 1'b1});
        expQ.push_back(exp_t'{2'd2, 8'd128, 1'b1});
        pushCount += 2;
        acc = 0;
        last = 0;
        for (int k = 0; k < 30 && acc < 3; k++) begin
            if (k > 0) @(negedge clk);
            if (smp_ready_o === 1'b1) begin
                if (acc > 0) checkOutput("accept spacing", 32'(k - last), 32'd3);
                last = k;
                acc++;
            end
        end
        checkOutput("continuous accepts", 32'(acc), 32'd3);
        @(posedge clk);
        #1 smp_valid_i = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;

        applyStimulus(2'd1, 100, 100, 20, 1'b1, 1'b0, 0, 1'b1);

        // Accept at count 253 so the duty commit coincides with the counter wrap.
        n = 0;
        @(negedge clk);
        while (cycCnt != 8'd253 && n < 600) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wrap ready", 32'(smp_ready_o), 32'd1);
        smp_ch_i = 2'd1;
        smp_v_i = 12'd110;
        smp_i_i = 12'd100;
        step_i = 8'd20;
        en_i = 1'b1;
        smp_valid_i = 1'b1;
        expQ.push_back(exp_t'{2'd1, 8'd148, 1'b1});
        pushCount++;
        @(posedge clk);
        #1 smp_valid_i = 1'b0;
        checkPwmPeriod("wrap old", {8'd128, 8'd128, 8'd13});
        checkPwmPeriod("wrap new", {8'd128, 8'd148, 8'd13});

        // Reset while the sample is in MUL: result discarded, reset values appear immediately.
        @(negedge clk);
        smp_ch_i = 2'd0;
        smp_v_i = 12'd200;
        smp_i_i = 12'd200;
        step_i = 8'd4;
        en_i = 1'b1;
        smp_valid_i = 1'b1;
        checkOutput("pre-rst ready", 32'(smp_ready_o), 32'd1);
        @(posedge clk);
        #1 smp_valid_i = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("async rst duty", 32'(duty_o), 32'h808080);
        checkOutput("async rst dir", 32'(dir_o), 32'b111);
        checkOutput("async rst ready", 32'(smp_ready_o), 32'd1);
        checkOutput("async rst pwm", 32'(pwm_o), 32'd0);
        checkOutput("async rst upd_ch", 32'(upd_ch_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("post-rst duty", 32'(duty_o), 32'h808080);
        checkOutput("upd pulse count", 32'(updCount), 32'(pushCount));
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
